// File: rtl/vedic_pkg.sv
// Shared constants and FSM state encoding for the Vedic partial-product combiner.
package vedic_pkg;

  localparam int PP_W   = 32;
  localparam int PROD_W = 64;
  localparam int HALF_W = 16;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ADD_MID = 3'd1,
    ADD_LO  = 3'd2,
    ADD_HI  = 3'd3,
    NEG_LO  = 3'd4,
    NEG_HI  = 3'd5,
    DONE    = 3'd6
  } state_t;

endpackage

// File: rtl/vedic_pp_combiner_cla.sv
// 32-bit carry-lookahead adder: 4-bit lookahead groups, group carries chained.
module CLA_32bit (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        cin,
  output logic [31:0] sum,
  output logic        cout
);

  logic [31:0] g;
  logic [31:0] p;
  logic [32:0] c;

  assign g    = a & b;
  assign p    = a ^ b;
  assign c[0] = cin;

  for (genvar k = 0; k < 8; k++) begin : g_grp
    localparam int B = 4 * k;
    logic grp_g;
    logic grp_p;

    assign c[B+1] = g[B] | (p[B] & c[B]);
    assign c[B+2] = g[B+1] | (p[B+1] & g[B]) | (p[B+1] & p[B] & c[B]);
    assign c[B+3] = g[B+2] | (p[B+2] & g[B+1]) | (p[B+2] & p[B+1] & g[B])
                  | (p[B+2] & p[B+1] & p[B] & c[B]);

    assign grp_g  = g[B+3] | (p[B+3] & g[B+2]) | (p[B+3] & p[B+2] & g[B+1])
                  | (p[B+3] & p[B+2] & p[B+1] & g[B]);
    assign grp_p  = &p[B+3:B];
    assign c[B+4] = grp_g | (grp_p & c[B]);
  end

  assign sum  = p ^ c[31:0];
  assign cout = c[32];

endmodule

// File: rtl/vedic_pp_combiner.sv
// Sums four 32-bit Vedic partial products into a 64-bit product using one shared
// CLA over a fixed schedule. Define VEDIC_SIGNED_EN to add the two-state negation pass.
module vedic_pp_combiner
  import vedic_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [PP_W-1:0]   pp_ll,
  input  logic [PP_W-1:0]   pp_hl,
  input  logic [PP_W-1:0]   pp_lh,
  input  logic [PP_W-1:0]   pp_hh,
  input  logic              neg,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [PROD_W-1:0] product
);

  state_t state;
  state_t state_nxt;

  logic [PP_W-1:0] ll_q, hl_q, lh_q, hh_q;
  logic [PP_W-1:0] mid, lo, hi;
  logic            mc, c1;

  logic [PP_W-1:0] add_a, add_b, add_sum;
  logic            add_cin, add_cout;
  logic            accept;

`ifdef VEDIC_SIGNED_EN
  logic neg_q;
  logic cn;
`else
  logic unused_neg;
  assign unused_neg = neg;
`endif

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign accept    = in_valid && in_ready;
  assign product   = {hi, lo};

  CLA_32bit u_cla (
    .a    (add_a),
    .b    (add_b),
    .cin  (add_cin),
    .sum  (add_sum),
    .cout (add_cout)
  );

  // NOTE: every signal driven here gets a default first, so no path can infer a latch.
  always_comb begin
    state_nxt = state;
    add_a     = '0;
    add_b     = '0;
    add_cin   = 1'b0;
    case (state)
      IDLE:    if (accept) state_nxt = ADD_MID;
      ADD_MID: begin
        add_a     = hl_q;
        add_b     = lh_q;
        state_nxt = ADD_LO;
      end
      ADD_LO: begin
        add_a     = ll_q;
        add_b     = {mid[HALF_W-1:0], {HALF_W{1'b0}}};
        state_nxt = ADD_HI;
      end
      ADD_HI: begin
        // The mid-sum carry sits at bit 48, i.e. bit 16 of the high word.
        add_a     = hh_q;
        add_b     = {{(HALF_W-1){1'b0}}, mc, mid[PP_W-1:HALF_W]};
        add_cin   = c1;
`ifdef VEDIC_SIGNED_EN
        state_nxt = NEG_LO;
`else
        state_nxt = DONE;
`endif
      end
`ifdef VEDIC_SIGNED_EN
      NEG_LO: begin
        add_a     = lo ^ {PP_W{neg_q}};
        add_cin   = neg_q;
        state_nxt = NEG_HI;
      end
      NEG_HI: begin
        add_a     = hi ^ {PP_W{neg_q}};
        add_cin   = cn;
        state_nxt = DONE;
      end
`endif
      DONE:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  // NOTE: all datapath registers are reset too, so an aborted set leaves product at zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      ll_q  <= '0;
      hl_q  <= '0;
      lh_q  <= '0;
      hh_q  <= '0;
      mid   <= '0;
      lo    <= '0;
      hi    <= '0;
      mc    <= 1'b0;
      c1    <= 1'b0;
`ifdef VEDIC_SIGNED_EN
      neg_q <= 1'b0;
      cn    <= 1'b0;
`endif
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (accept) begin
            ll_q  <= pp_ll;
            hl_q  <= pp_hl;
            lh_q  <= pp_lh;
            hh_q  <= pp_hh;
`ifdef VEDIC_SIGNED_EN
            neg_q <= neg;
`endif
          end
        end
        ADD_MID: begin
          mid <= add_sum;
          mc  <= add_cout;
        end
        ADD_LO: begin
          lo <= add_sum;
          c1 <= add_cout;
        end
        ADD_HI:  hi <= add_sum;
`ifdef VEDIC_SIGNED_EN
        NEG_LO: begin
          lo <= add_sum;
          cn <= add_cout;
        end
        NEG_HI:  hi <= add_sum;
`endif
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_vedic_pp_combiner.sv
// Directed bench for vedic_pp_combiner; expectations follow VEDIC_SIGNED_EN.
module tb_vedic_pp_combiner;

`ifdef VEDIC_SIGNED_EN
  localparam bit SIGNED_BUILD = 1'b1;
  localparam int LAT_EDGES    = 5;
`else
  localparam bit SIGNED_BUILD = 1'b0;
  localparam int LAT_EDGES    = 3;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] pp_ll = '0, pp_hl = '0, pp_lh = '0, pp_hh = '0;
  logic        neg = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [63:0] product;

  int checks   = 0;
  int failures = 0;

  vedic_pp_combiner dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .pp_ll     (pp_ll),
    .pp_hl     (pp_hl),
    .pp_lh     (pp_lh),
    .pp_hh     (pp_hh),
    .neg       (neg),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .product   (product)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic send(input logic [31:0] ll, hl, lh, hh, input logic n);
    @(negedge clk);
    pp_ll = ll; pp_hl = hl; pp_lh = lh; pp_hh = hh; neg = n;
    in_valid = 1'b1;
    check("in_ready_before_accept", 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    pp_ll = $urandom; pp_hl = $urandom; pp_lh = $urandom; pp_hh = $urandom;
    neg = 1'($urandom);
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    while (!out_valid && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    check({tag, "_latency"}, 64'(n), 64'(LAT_EDGES));
  endtask

  task automatic complete(input string tag, input logic [63:0] exp);
    check({tag, "_product"}, product, exp);
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check({tag, "_out_valid_after"}, 64'(out_valid), 64'd0);
    check({tag, "_in_ready_after"}, 64'(in_ready), 64'd1);
  endtask

  initial begin
    // Reset state
    #1;
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_product", product, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // All-zero partial products
    send(32'h0, 32'h0, 32'h0, 32'h0, 1'b0);
    wait_done("zero");
    complete("zero", 64'h0);

    // 0xFFFFFFFF squared
    send(32'hFFFE0001, 32'hFFFE0001, 32'hFFFE0001, 32'hFFFE0001, 1'b0);
    wait_done("max_sq");
    complete("max_sq", 64'hFFFFFFFE00000001);

    // Mid carry lands at bit 48, with backpressure and in_valid toggling in DONE
    send(32'h0, 32'h80000000, 32'h80000000, 32'h0, 1'b0);
    wait_done("mid_carry");
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      in_valid = ~in_valid;
      pp_ll = $urandom; pp_hl = $urandom; pp_lh = $urandom; pp_hh = $urandom;
      @(posedge clk); #1;
      check("bp_product_stable", product, 64'h0001000000000000);
      check("bp_in_ready_low", 64'(in_ready), 64'd0);
      check("bp_out_valid_held", 64'(out_valid), 64'd1);
    end
    in_valid = 1'b0;
    complete("mid_carry", 64'h0001000000000000);
    repeat (8) @(posedge clk);
    #1;
    check("bp_no_phantom_set", 64'(out_valid), 64'd0);

    // Negation of one, and of zero
    send(32'h1, 32'h0, 32'h0, 32'h0, 1'b1);
    wait_done("neg_one");
    complete("neg_one", SIGNED_BUILD ? 64'hFFFFFFFFFFFFFFFF : 64'h1);

    send(32'h0, 32'h0, 32'h0, 32'h0, 1'b1);
    wait_done("neg_zero");
    complete("neg_zero", 64'h0);

    // Mixed set: magnitude 0x1_FFFFFFFF
    send(32'hFFFFFFFF, 32'h00010000, 32'h0, 32'h0, 1'b1);
    wait_done("mixed");
    complete("mixed", SIGNED_BUILD ? 64'hFFFFFFFE00000001 : 64'h00000001FFFFFFFF);

    // Reset pulsed during ADD_HI
    send(32'hFFFE0001, 32'hFFFE0001, 32'hFFFE0001, 32'hFFFE0001, 1'b0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check("abort_out_valid", 64'(out_valid), 64'd0);
    check("abort_product", product, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("abort_in_ready", 64'(in_ready), 64'd1);
    repeat (8) @(posedge clk);
    #1;
    check("abort_no_result", 64'(out_valid), 64'd0);

    send(32'h0, 32'h80000000, 32'h80000000, 32'h0, 1'b0);
    wait_done("post_abort");
    complete("post_abort", 64'h0001000000000000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/vedic_pp_combiner.md
# vedic_pp_combiner

Multi-cycle stage that takes the four 32-bit partial products of a 32x32 Vedic multiply (LL, HL, LH, HH), sums them into a 64-bit magnitude, and optionally applies the result sign. It sits between the 16x16 Vedic sub-multipliers and the product output register. It time-shares one 32-bit carry-lookahead adder across a fixed add schedule instead of instantiating four adders.

## Interface
- No parameters. Widths are fixed by package constants.
- `clk`: input, 1 bit. Single clock; all state updates on its rising edge.
- `rst_n`: input, 1 bit. Reset, asynchronous and active-low.
- `in_valid`: input, 1 bit. Partial-product set is valid.
- `in_ready`: output, 1 bit. Block is idle and can accept a set.
- `pp_ll`, `pp_hl`, `pp_lh`, `pp_hh`: input, 32 bits each. Unsigned partial products a_lo·b_lo, a_hi·b_lo, a_lo·b_hi, a_hi·b_hi.
- `neg`: input, 1 bit. Result sign (sign_a XOR sign_b).
- `out_valid`: output, 1 bit. `product` is valid and held.
- `out_ready`: input, 1 bit. Consumer accepts `product`.
- `product`: output, 64 bits. Final product.

## Operation
- Math: P = pp_ll + ((pp_hl + pp_lh) << 16) + (pp_hh << 32). If signed, the result is −P mod 2^64.
- All inputs are captured into internal registers on accept, when `in_valid && in_ready`. Inputs are ignored at every other time.
- The FSM uses one adder: 32-bit a + b + cin → 32-bit sum plus carry. States in order:
  - IDLE: `in_ready`=1. On accept → ADD_MID.
  - ADD_MID: {mc, mid} = pp_hl + pp_lh + 0. This is a 33-bit result.
  - ADD_LO: {c1, lo} = pp_ll + {mid[15:0], 16'h0} + 0.
  - ADD_HI: hi = pp_hh + {15'h0, mc, mid[31:16]} + c1. The carry-out is provably 0 and is discarded.
  - NEG_LO (signed build only): {cn, lo} = (lo ^ {32{neg}}) + 0 + neg.
  - NEG_HI (signed build only): hi = (hi ^ {32{neg}}) + 0 + cn.
  - DONE: `out_valid`=1, `product`={hi, lo}. On `out_ready` → IDLE.
- The negation states are always traversed, so latency is fixed. When `neg`=0 they pass values through unchanged.
- The zero product with `neg`=1 yields 0, because the carry ripples through both halves.
- `product` is driven from registers only. It is stable for the whole time `out_valid`=1.

## Timing
- Reset values: state IDLE, `in_ready`=1, `out_valid`=0, `product`=0. All internal registers are cleared.
- Reset asserted at any point, including mid-schedule: the operation is aborted and outputs go to their reset values immediately. No result is produced for the aborted set.
- Signed build timing, with accept at edge 0:
  - ADD_MID at cycle 1, ADD_LO at cycle 2, ADD_HI at cycle 3, NEG_LO at cycle 4, NEG_HI at cycle 5.
  - `out_valid` rises at cycle 6.
- Unsigned build: `out_valid` rises at cycle 4.
- Handshake completes on the edge where `out_valid && out_ready`. `in_ready` returns high in the next cycle. There is no same-cycle accept/complete overlap.
- Peak throughput is one set per 7 cycles (signed build) or per 5 cycles (unsigned build).
- `in_ready`=0 from accept until the cycle after output handshake. `in_valid` is ignored during that window.
- `out_ready` may stay low indefinitely. The block holds in DONE with `product` stable.

## Configuration
- The macro is `VEDIC_SIGNED_EN`.
- Defined: NEG_LO and NEG_HI are present, `neg` is honoured, and latency is 6.
- Undefined: both states are removed, `neg` is unused, `product` is the unsigned magnitude, and latency is 4.

## Structure
- Shared package `vedic_pkg` holds:
  - Width constants: PP_W=32, PROD_W=64, HALF_W=16.
  - The FSM state typedef (IDLE, ADD_MID, ADD_LO, ADD_HI, NEG_LO, NEG_HI, DONE).
- One sub-module: the team's existing 32-bit carry-lookahead adder `CLA_32bit`, instantiated once. Its operand and carry-in muxes are selected by state.

## Test plan
- All four partial products 0, `neg`=0: `product`=64'h0 at cycle 6, then `in_ready`=1 one cycle after `out_ready`.
- All four partial products 32'hFFFE0001, `neg`=0 (the 32'hFFFFFFFF² case): `product`=64'hFFFFFFFE00000001.
- `pp_hl`=`pp_lh`=32'h80000000, other products 0: `product`=64'h0001000000000000. This checks that the mid carry mc lands at bit 48.
- `pp_ll`=1, others 0, `neg`=1: `product`=64'hFFFFFFFFFFFFFFFF. The same set with `pp_ll`=0 gives 64'h0.
- Backpressure: `out_ready`=0 for 3 cycles in DONE with `in_valid` toggling. `product` must stay stable, `in_ready`=0, and no new set is captured.
- `rst_n` pulsed low during ADD_HI: `out_valid`=0 and `product`=0 immediately. `in_ready`=1 after release, and the next set completes normally.
